// File: rtl/msrh_lrq_core_if.sv
// rtl/msrh_lrq_core_if.sv - miss request, L2 refill and resolve signal bundle for the load refill queue
interface msrh_lrq_core_if #(
  parameter int LRQ_SIZE   = 4,
  parameter int PADDR_W    = 40,
  parameter int LINE_OFS_W = 6
);
  localparam int TAG_W  = $clog2(LRQ_SIZE);
  localparam int LINE_W = PADDR_W - LINE_OFS_W;

  logic                i_req_valid;
  logic [PADDR_W-1:0]  i_req_paddr;
  logic                o_resp_valid;
  logic [1:0]          o_resp_typ;
  logic [LRQ_SIZE-1:0] o_resp_index_oh;

  logic                o_l2_req_valid;
  logic [TAG_W-1:0]    o_l2_req_tag;
  logic [LINE_W-1:0]   o_l2_req_line;
  logic                i_l2_req_ready;

  logic                i_l2_resp_valid;
  logic [TAG_W-1:0]    i_l2_resp_tag;

  logic                o_resolve_valid;
  logic [LRQ_SIZE-1:0] o_resolve_index_oh;
  logic                o_full;

  // Requester / L2 side: drives the i_* signals, observes the o_* signals.
  modport master (
    output i_req_valid, i_req_paddr, i_l2_req_ready, i_l2_resp_valid, i_l2_resp_tag,
    input  o_resp_valid, o_resp_typ, o_resp_index_oh, o_l2_req_valid, o_l2_req_tag,
           o_l2_req_line, o_resolve_valid, o_resolve_index_oh, o_full
  );

  // Queue side.
  modport slave (
    input  i_req_valid, i_req_paddr, i_l2_req_ready, i_l2_resp_valid, i_l2_resp_tag,
    output o_resp_valid, o_resp_typ, o_resp_index_oh, o_l2_req_valid, o_l2_req_tag,
           o_l2_req_line, o_resolve_valid, o_resolve_index_oh, o_full
  );
endinterface

// File: rtl/msrh_lrq_core.sv
// rtl/msrh_lrq_core.sv - load refill queue: miss merge, L2 refill request and resolve broadcast
module msrh_lrq_core #(
  parameter int LRQ_SIZE   = 4,
  parameter int PADDR_W    = 40,
  parameter int LINE_OFS_W = 6
) (
  input logic              i_clk,
  input logic              i_reset,
  msrh_lrq_core_if.slave   lrq
);
  localparam int TAG_W  = $clog2(LRQ_SIZE);
  localparam int LINE_W = PADDR_W - LINE_OFS_W;

  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_WAIT_REQ  = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_RESOLVE   = 2'd3
  } entry_state_e;

  entry_state_e        state_q [LRQ_SIZE];
  entry_state_e        state_d [LRQ_SIZE];
  logic [LINE_W-1:0]   line_q  [LRQ_SIZE];

  logic [LINE_W-1:0]   req_line;
  logic [LRQ_SIZE-1:0] hit;
  logic [LRQ_SIZE-1:0] free_vec;
  logic [LRQ_SIZE-1:0] free_oh;
  logic [LRQ_SIZE-1:0] alloc_oh;
  logic [LRQ_SIZE-1:0] resolve_vec;
  logic                wr_any;
  logic [TAG_W-1:0]    wr_idx;
  logic                lock_q;
  logic [TAG_W-1:0]    lock_idx_q;
  logic                l2_valid;
  logic [TAG_W-1:0]    l2_idx;
  logic                l2_hs;
  logic                full;
  logic                unused_ofs;

  assign req_line   = lrq.i_req_paddr[PADDR_W-1:LINE_OFS_W];
  assign unused_ofs = ^lrq.i_req_paddr[LINE_OFS_W-1:0];

  // Per-entry classification: line hit, free slots, resolving slot, lowest WAIT_REQ entry.
  always_comb begin
    hit         = '0;
    free_vec    = '0;
    resolve_vec = '0;
    wr_any      = 1'b0;
    wr_idx      = '0;
    for (int i = 0; i < LRQ_SIZE; i++) begin
      free_vec[i]    = (state_q[i] == ST_FREE);
      hit[i]         = (state_q[i] != ST_FREE) && (line_q[i] == req_line);
      resolve_vec[i] = (state_q[i] == ST_RESOLVE);
    end
    for (int i = LRQ_SIZE - 1; i >= 0; i--) begin
      if (state_q[i] == ST_WAIT_REQ) begin
        wr_any = 1'b1;
        wr_idx = TAG_W'(i);
      end
    end
  end

  // Lowest FREE entry; an entry leaving RESOLVE is not FREE yet, so it cannot be reused this cycle.
  assign free_oh  = free_vec & (~free_vec + LRQ_SIZE'(1));
  assign full     = (free_vec == '0);
  assign alloc_oh = (lrq.i_req_valid && (hit == '0) && !full) ? free_oh : '0;

  // Miss response classification.
  always_comb begin
    lrq.o_resp_typ      = 2'b00;
    lrq.o_resp_index_oh = '0;
    if (lrq.i_req_valid) begin
      if (hit != '0) begin
        lrq.o_resp_typ      = 2'b01;
        lrq.o_resp_index_oh = hit;
      end else if (full) begin
        lrq.o_resp_typ = 2'b10;
      end
    end
  end

  // A stalled L2 request is pinned so a later, lower-index allocation cannot swap it out.
  assign l2_valid = lock_q | wr_any;
  assign l2_idx   = lock_q ? lock_idx_q : wr_idx;
  assign l2_hs    = l2_valid & lrq.i_l2_req_ready;

  assign lrq.o_resp_valid       = lrq.i_req_valid;
  assign lrq.o_l2_req_valid     = l2_valid;
  assign lrq.o_l2_req_tag       = l2_idx;
  assign lrq.o_l2_req_line      = line_q[l2_idx];
  assign lrq.o_resolve_valid    = (resolve_vec != '0);
  assign lrq.o_resolve_index_oh = resolve_vec;
  assign lrq.o_full             = full;

  // Per-entry lifecycle: FREE -> WAIT_REQ -> WAIT_RESP -> RESOLVE -> FREE.
  always_comb begin
    for (int i = 0; i < LRQ_SIZE; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_FREE:      if (alloc_oh[i]) state_d[i] = ST_WAIT_REQ;
        ST_WAIT_REQ:  if (l2_hs && (l2_idx == TAG_W'(i))) state_d[i] = ST_WAIT_RESP;
        ST_WAIT_RESP: if (lrq.i_l2_resp_valid && (lrq.i_l2_resp_tag == TAG_W'(i))) state_d[i] = ST_RESOLVE;
        default:      state_d[i] = ST_FREE;
      endcase
    end
  end

  // Entry state, line capture on allocation, and L2 request pinning.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < LRQ_SIZE; i++) begin
        state_q[i] <= ST_FREE;
        line_q[i]  <= '0;
      end
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      for (int i = 0; i < LRQ_SIZE; i++) begin
        state_q[i] <= state_d[i];
        if (alloc_oh[i]) line_q[i] <= req_line;
      end
      lock_q     <= l2_valid & ~lrq.i_l2_req_ready;
      lock_idx_q <= l2_idx;
    end
  end
endmodule

// File: tb/tb_msrh_lrq_core.sv
// tb/tb_msrh_lrq_core.sv - directed self-checking bench for msrh_lrq_core
module tb_msrh_lrq_core;
  logic i_clk;
  logic i_reset;
  int   cmps;
  int   errs;

  msrh_lrq_core_if #(.LRQ_SIZE(4), .PADDR_W(40), .LINE_OFS_W(6)) lrq ();

  msrh_lrq_core #(.LRQ_SIZE(4), .PADDR_W(40), .LINE_OFS_W(6)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .lrq     (lrq.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    lrq.i_req_valid     = 1'b0;
    lrq.i_req_paddr     = '0;
    lrq.i_l2_req_ready  = 1'b0;
    lrq.i_l2_resp_valid = 1'b0;
    lrq.i_l2_resp_tag   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  task automatic req(input logic [39:0] pa);
    lrq.i_req_valid = 1'b1;
    lrq.i_req_paddr = pa;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    cmps++; if (lrq.o_l2_req_valid !== 1'b0) begin errs++; $display("FAIL reset_l2_valid got=%0h exp=0", lrq.o_l2_req_valid); end
    cmps++; if (lrq.o_resolve_valid !== 1'b0) begin errs++; $display("FAIL reset_resolve_valid got=%0h exp=0", lrq.o_resolve_valid); end
    cmps++; if (lrq.o_resolve_index_oh !== 4'b0000) begin errs++; $display("FAIL reset_resolve_idx got=%0h exp=0", lrq.o_resolve_index_oh); end
    cmps++; if (lrq.o_full !== 1'b0) begin errs++; $display("FAIL reset_full got=%0h exp=0", lrq.o_full); end
    cmps++; if ({lrq.o_resp_valid, lrq.o_resp_typ, lrq.o_resp_index_oh} !== 7'b0) begin errs++; $display("FAIL reset_resp got=%0h exp=0", {lrq.o_resp_valid, lrq.o_resp_typ, lrq.o_resp_index_oh}); end
  endtask

  task automatic test_basic_flow();
    do_reset();
    req(40'h1000);
    settle();
    cmps++; if ({lrq.o_resp_valid, lrq.o_resp_typ, lrq.o_resp_index_oh} !== {1'b1, 2'b00, 4'b0000}) begin errs++; $display("FAIL basic_assigned got=%0h exp=%0h", {lrq.o_resp_valid, lrq.o_resp_typ, lrq.o_resp_index_oh}, {1'b1, 2'b00, 4'b0000}); end
    cmps++; if (lrq.o_l2_req_valid !== 1'b0) begin errs++; $display("FAIL basic_l2_alloc_cycle got=%0h exp=0", lrq.o_l2_req_valid); end
    tick();
    lrq.i_req_valid = 1'b0;
    lrq.i_l2_req_ready = 1'b1;
    settle();
    cmps++; if ({lrq.o_l2_req_valid, lrq.o_l2_req_tag} !== {1'b1, 2'd0}) begin errs++; $display("FAIL basic_l2_req got=%0h exp=%0h", {lrq.o_l2_req_valid, lrq.o_l2_req_tag}, {1'b1, 2'd0}); end
    cmps++; if (lrq.o_l2_req_line !== 34'h40) begin errs++; $display("FAIL basic_l2_line got=%0h exp=40", lrq.o_l2_req_line); end
    tick();
    lrq.i_l2_req_ready = 1'b0;
    settle();
    cmps++; if (lrq.o_l2_req_valid !== 1'b0) begin errs++; $display("FAIL basic_l2_after_hs got=%0h exp=0", lrq.o_l2_req_valid); end
    tick();
    tick();
    tick();
    lrq.i_l2_resp_valid = 1'b1;
    lrq.i_l2_resp_tag = 2'd0;
    settle();
    cmps++; if (lrq.o_resolve_valid !== 1'b0) begin errs++; $display("FAIL basic_resolve_early got=%0h exp=0", lrq.o_resolve_valid); end
    tick();
    lrq.i_l2_resp_valid = 1'b0;
    settle();
    cmps++; if ({lrq.o_resolve_valid, lrq.o_resolve_index_oh} !== {1'b1, 4'b0001}) begin errs++; $display("FAIL basic_resolve got=%0h exp=%0h", {lrq.o_resolve_valid, lrq.o_resolve_index_oh}, {1'b1, 4'b0001}); end
    tick();
    cmps++; if ({lrq.o_resolve_valid, lrq.o_resolve_index_oh} !== 5'b0) begin errs++; $display("FAIL basic_resolve_once got=%0h exp=0", {lrq.o_resolve_valid, lrq.o_resolve_index_oh}); end
  endtask

  task automatic test_conflict();
    do_reset();
    req(40'h1000);
    tick();
    req(40'h1020);
    settle();
    cmps++; if ({lrq.o_resp_typ, lrq.o_resp_index_oh} !== {2'b01, 4'b0001}) begin errs++; $display("FAIL conflict_resp got=%0h exp=%0h", {lrq.o_resp_typ, lrq.o_resp_index_oh}, {2'b01, 4'b0001}); end
    tick();
    req(40'h3000);
    settle();
    cmps++; if ({lrq.o_resp_typ, lrq.o_resp_index_oh} !== 6'b0) begin errs++; $display("FAIL conflict_next_assigned got=%0h exp=0", {lrq.o_resp_typ, lrq.o_resp_index_oh}); end
    tick();
    lrq.i_req_valid = 1'b0;
    lrq.i_l2_req_ready = 1'b1;
    tick();
    settle();
    cmps++; if ({lrq.o_l2_req_valid, lrq.o_l2_req_tag, lrq.o_l2_req_line} !== {1'b1, 2'd1, 34'hC0}) begin errs++; $display("FAIL conflict_no_alloc got=%0h exp=%0h", {lrq.o_l2_req_valid, lrq.o_l2_req_tag, lrq.o_l2_req_line}, {1'b1, 2'd1, 34'hC0}); end
    lrq.i_l2_req_ready = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req(40'h1000 * (k + 1));
      settle();
      cmps++; if ({lrq.o_resp_typ, lrq.o_full} !== 3'b000) begin errs++; $display("FAIL full_fill%0d got=%0h exp=0", k, {lrq.o_resp_typ, lrq.o_full}); end
      tick();
    end
    req(40'h5000);
    settle();
    cmps++; if (lrq.o_full !== 1'b1) begin errs++; $display("FAIL full_flag got=%0h exp=1", lrq.o_full); end
    cmps++; if ({lrq.o_resp_typ, lrq.o_resp_index_oh} !== {2'b10, 4'b0000}) begin errs++; $display("FAIL full_resp got=%0h exp=%0h", {lrq.o_resp_typ, lrq.o_resp_index_oh}, {2'b10, 4'b0000}); end
    lrq.i_req_valid = 1'b0;
    lrq.i_l2_req_ready = 1'b1;
    tick();
    lrq.i_l2_req_ready = 1'b0;
    lrq.i_l2_resp_valid = 1'b1;
    lrq.i_l2_resp_tag = 2'd0;
    tick();
    lrq.i_l2_resp_valid = 1'b0;
    req(40'h5000);
    settle();
    cmps++; if ({lrq.o_resolve_index_oh, lrq.o_full, lrq.o_resp_typ} !== {4'b0001, 1'b1, 2'b10}) begin errs++; $display("FAIL full_resolve_cycle got=%0h exp=%0h", {lrq.o_resolve_index_oh, lrq.o_full, lrq.o_resp_typ}, {4'b0001, 1'b1, 2'b10}); end
    tick();
    cmps++; if ({lrq.o_full, lrq.o_resp_typ, lrq.o_resp_index_oh} !== 7'b0) begin errs++; $display("FAIL full_reassign got=%0h exp=0", {lrq.o_full, lrq.o_resp_typ, lrq.o_resp_index_oh}); end
    tick();
    lrq.i_req_valid = 1'b0;
    settle();
    cmps++; if (lrq.o_full !== 1'b1) begin errs++; $display("FAIL full_refilled got=%0h exp=1", lrq.o_full); end
  endtask

  task automatic test_l2_stall();
    do_reset();
    req(40'h1000);
    tick();
    req(40'h2000);
    lrq.i_l2_req_ready = 1'b1;
    tick();
    lrq.i_req_valid = 1'b0;
    settle();
    cmps++; if ({lrq.o_l2_req_valid, lrq.o_l2_req_tag} !== {1'b1, 2'd1}) begin errs++; $display("FAIL stall_tag1 got=%0h exp=%0h", {lrq.o_l2_req_valid, lrq.o_l2_req_tag}, {1'b1, 2'd1}); end
    tick();
    lrq.i_l2_req_ready = 1'b0;
    lrq.i_l2_resp_valid = 1'b1;
    lrq.i_l2_resp_tag = 2'd0;
    tick();
    lrq.i_l2_resp_valid = 1'b0;
    tick();
    req(40'h3000);
    tick();
    req(40'h4000);
    settle();
    cmps++; if ({lrq.o_l2_req_valid, lrq.o_l2_req_tag, lrq.o_l2_req_line} !== {1'b1, 2'd0, 34'hC0}) begin errs++; $display("FAIL stall_c1 got=%0h exp=%0h", {lrq.o_l2_req_valid, lrq.o_l2_req_tag, lrq.o_l2_req_line}, {1'b1, 2'd0, 34'hC0}); end
    tick();
    lrq.i_req_valid = 1'b0;
    settle();
    cmps++; if ({lrq.o_l2_req_valid, lrq.o_l2_req_tag, lrq.o_l2_req_line} !== {1'b1, 2'd0, 34'hC0}) begin errs++; $display("FAIL stall_c2 got=%0h exp=%0h", {lrq.o_l2_req_valid, lrq.o_l2_req_tag, lrq.o_l2_req_line}, {1'b1, 2'd0, 34'hC0}); end
    tick();
    cmps++; if ({lrq.o_l2_req_valid, lrq.o_l2_req_tag, lrq.o_l2_req_line} !== {1'b1, 2'd0, 34'hC0}) begin errs++; $display("FAIL stall_c3 got=%0h exp=%0h", {lrq.o_l2_req_valid, lrq.o_l2_req_tag, lrq.o_l2_req_line}, {1'b1, 2'd0, 34'hC0}); end
    lrq.i_l2_req_ready = 1'b1;
    tick();
    lrq.i_l2_req_ready = 1'b0;
    settle();
    cmps++; if ({lrq.o_l2_req_valid, lrq.o_l2_req_tag, lrq.o_l2_req_line} !== {1'b1, 2'd2, 34'h100}) begin errs++; $display("FAIL stall_next got=%0h exp=%0h", {lrq.o_l2_req_valid, lrq.o_l2_req_tag, lrq.o_l2_req_line}, {1'b1, 2'd2, 34'h100}); end
  endtask

  task automatic test_resolve_conflict();
    do_reset();
    req(40'h1000);
    tick();
    lrq.i_req_valid = 1'b0;
    lrq.i_l2_req_ready = 1'b1;
    tick();
    lrq.i_l2_req_ready = 1'b0;
    lrq.i_l2_resp_valid = 1'b1;
    lrq.i_l2_resp_tag = 2'd0;
    tick();
    lrq.i_l2_resp_valid = 1'b0;
    req(40'h1000);
    settle();
    cmps++; if ({lrq.o_resp_typ, lrq.o_resp_index_oh, lrq.o_resolve_valid, lrq.o_resolve_index_oh} !== {2'b01, 4'b0001, 1'b1, 4'b0001}) begin errs++; $display("FAIL rc_conflict got=%0h exp=%0h", {lrq.o_resp_typ, lrq.o_resp_index_oh, lrq.o_resolve_valid, lrq.o_resolve_index_oh}, {2'b01, 4'b0001, 1'b1, 4'b0001}); end
    tick();
    cmps++; if ({lrq.o_resp_typ, lrq.o_resp_index_oh} !== 6'b0) begin errs++; $display("FAIL rc_reassign got=%0h exp=0", {lrq.o_resp_typ, lrq.o_resp_index_oh}); end
    tick();
    lrq.i_req_valid = 1'b0;
    lrq.i_l2_resp_valid = 1'b1;
    lrq.i_l2_resp_tag = 2'd3;
    tick();
    lrq.i_l2_resp_valid = 1'b0;
    settle();
    cmps++; if ({lrq.o_resolve_valid, lrq.o_l2_req_valid, lrq.o_l2_req_tag, lrq.o_full} !== {1'b0, 1'b1, 2'd0, 1'b0}) begin errs++; $display("FAIL rc_stray got=%0h exp=%0h", {lrq.o_resolve_valid, lrq.o_l2_req_valid, lrq.o_l2_req_tag, lrq.o_full}, {1'b0, 1'b1, 2'd0, 1'b0}); end
    tick();
    cmps++; if (lrq.o_resolve_valid !== 1'b0) begin errs++; $display("FAIL rc_stray_late got=%0h exp=0", lrq.o_resolve_valid); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req(40'h1000);
    tick();
    req(40'h2000);
    lrq.i_l2_req_ready = 1'b1;
    tick();
    lrq.i_req_valid = 1'b0;
    tick();
    lrq.i_l2_req_ready = 1'b0;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    settle();
    cmps++; if ({lrq.o_l2_req_valid, lrq.o_resolve_valid, lrq.o_full} !== 3'b000) begin errs++; $display("FAIL mrst_state got=%0h exp=0", {lrq.o_l2_req_valid, lrq.o_resolve_valid, lrq.o_full}); end
    lrq.i_l2_resp_valid = 1'b1;
    lrq.i_l2_resp_tag = 2'd1;
    tick();
    lrq.i_l2_resp_valid = 1'b0;
    req(40'h2000);
    settle();
    cmps++; if ({lrq.o_resolve_valid, lrq.o_resp_typ, lrq.o_resp_index_oh} !== 7'b0) begin errs++; $display("FAIL mrst_after got=%0h exp=0", {lrq.o_resolve_valid, lrq.o_resp_typ, lrq.o_resp_index_oh}); end
    tick();
    lrq.i_req_valid = 1'b0;
    settle();
    cmps++; if (lrq.o_resolve_valid !== 1'b0) begin errs++; $display("FAIL mrst_late got=%0h exp=0", lrq.o_resolve_valid); end
  endtask

  initial begin
    cmps = 0;
    errs = 0;
    i_reset = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_flow();
    test_conflict();
    test_full();
    test_l2_stall();
    test_resolve_conflict();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
